// File: rtl/ysyx_22050710_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_22050710_fetch_ctrl_pkg;

  localparam int unsigned PC_WD_DEF   = 64;
  localparam int unsigned INST_WD_DEF = 32;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_REQ   = 3'd1,
    FETCH_WAIT  = 3'd2,
    FETCH_HOLD  = 3'd3,
    FETCH_REDIR = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/ysyx_22050710_fetch_ctrl_if.sv
// Bundle of PC, redirect, imem and decode signals around the fetch controller.
// Latency: n/a (wires only).
// Backpressure: valid/ready on imem request and decode; imem response has no ready.
//
// Ports (seen from the controller, modport master):
//   PC       : i_pc in, o_pc_load / o_br_sel / o_br_target out
//   redirect : i_redirect, i_redirect_pc in
//   imem req : o_imem_req_valid, o_imem_addr out, i_imem_req_ready in
//   imem rsp : i_imem_rsp_valid, i_imem_rsp_data, i_imem_rsp_err in
//   decode   : o_inst_valid, o_inst, o_inst_pc, o_inst_err out, i_inst_ready in
//   status   : o_busy out
// The slave modport is the mirror image, used by the surrounding core or a bench.
interface ysyx_22050710_fetch_ctrl_if
  import ysyx_22050710_fetch_ctrl_pkg::*;
#(
  parameter int PC_WD   = PC_WD_DEF,
  parameter int INST_WD = INST_WD_DEF
);

  logic [PC_WD-1:0]   i_pc;
  logic               o_pc_load;
  logic               o_br_sel;
  logic [PC_WD-1:0]   o_br_target;

  logic               i_redirect;
  logic [PC_WD-1:0]   i_redirect_pc;

  logic               o_imem_req_valid;
  logic               i_imem_req_ready;
  logic [PC_WD-1:0]   o_imem_addr;

  logic               i_imem_rsp_valid;
  logic [INST_WD-1:0] i_imem_rsp_data;
  logic               i_imem_rsp_err;

  logic               o_inst_valid;
  logic               i_inst_ready;
  logic [INST_WD-1:0] o_inst;
  logic [PC_WD-1:0]   o_inst_pc;
  logic               o_inst_err;

  logic               o_busy;

  modport master (
    input  i_pc, i_redirect, i_redirect_pc, i_imem_req_ready,
           i_imem_rsp_valid, i_imem_rsp_data, i_imem_rsp_err, i_inst_ready,
    output o_pc_load, o_br_sel, o_br_target, o_imem_req_valid, o_imem_addr,
           o_inst_valid, o_inst, o_inst_pc, o_inst_err, o_busy
  );

  modport slave (
    output i_pc, i_redirect, i_redirect_pc, i_imem_req_ready,
           i_imem_rsp_valid, i_imem_rsp_data, i_imem_rsp_err, i_inst_ready,
    input  o_pc_load, o_br_sel, o_br_target, o_imem_req_valid, o_imem_addr,
           o_inst_valid, o_inst, o_inst_pc, o_inst_err, o_busy
  );

endinterface

// File: rtl/ysyx_22050710_fetch_ctrl_reg.sv
// Generic enabled register cell with asynchronous active-low reset.
// Latency: 1 cycle from din/wen to dout.
// Backpressure: none; holds its value while wen is low.
//
// Ports: clk, rst_n, wen (load enable), din (next value), dout (stored value).
module ysyx_22050710_fetch_ctrl_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_22050710_fetch_ctrl.sv
// Instruction fetch controller: issues one imem request per PC, holds the
// returned instruction for decode, and steers the PC on sequential advance or redirect.
// Latency: request in the cycle after IDLE/REDIR/handshake; instruction valid 1 cycle after the imem response.
// Backpressure: request held stable until imem ready; instruction held stable until decode ready.
//
// Ports: i_clk, i_rst_n (async active-low), bus (fetch_ctrl_if.master: PC, redirect,
// imem request/response, decode and busy signals).
module ysyx_22050710_fetch_ctrl
  import ysyx_22050710_fetch_ctrl_pkg::*;
#(
  parameter int PC_WD   = PC_WD_DEF,
  parameter int INST_WD = INST_WD_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  ysyx_22050710_fetch_ctrl_if.master bus
);

  fetch_state_e       state_q, state_d;
  logic [PC_WD-1:0]   issued_pc_q;
  logic [PC_WD-1:0]   inst_pc_q;
  logic [INST_WD-1:0] inst_q;
  logic               inst_err_q;
  logic               pending_q;
  logic               kill_q;
  logic [PC_WD-1:0]   target_q;

  logic req_vld;
  logic accept;
  logic capture;
  logic pc_load;
  logic br_sel;

  // Latest redirect target; every redirect overwrites it so the newest one wins.
  ysyx_22050710_fetch_ctrl_reg #(
    .WIDTH    (PC_WD),
    .RESET_VAL({PC_WD{1'b0}})
  ) u_target_reg (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .wen  (bus.i_redirect),
    .din  (bus.i_redirect_pc),
    .dout (target_q)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= FETCH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_vld = 1'b0;
    accept  = 1'b0;
    capture = 1'b0;
    pc_load = 1'b0;
    br_sel  = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        state_d = bus.i_redirect ? FETCH_REDIR : FETCH_REQ;
      end
      FETCH_REQ: begin
        // A redirect here only marks the fetch as killed; the request itself
        // must stay up until the memory takes it.
        req_vld = 1'b1;
        if (bus.i_imem_req_ready) begin
          accept  = 1'b1;
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (bus.i_imem_rsp_valid) begin
          if (pending_q || bus.i_redirect) begin
            state_d = FETCH_REDIR;
          end else begin
            capture = 1'b1;
            state_d = FETCH_HOLD;
          end
        end
      end
      FETCH_HOLD: begin
        // Redirect takes priority over sequential advance even if decode
        // consumes the instruction in the same cycle.
        if (bus.i_redirect) begin
          state_d = FETCH_REDIR;
        end else if (bus.i_inst_ready) begin
          pc_load = 1'b1;
          state_d = FETCH_REQ;
        end
      end
      FETCH_REDIR: begin
        pc_load = 1'b1;
        br_sel  = 1'b1;
        // A redirect arriving now updates the target; stay to load it too.
        if (!bus.i_redirect) begin
          state_d = FETCH_REQ;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      issued_pc_q <= '0;
      inst_pc_q   <= '0;
      inst_q      <= '0;
      inst_err_q  <= 1'b0;
      pending_q   <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      if (accept) begin
        issued_pc_q <= bus.i_pc;
      end
      if (capture) begin
        inst_q     <= bus.i_imem_rsp_data;
        inst_err_q <= bus.i_imem_rsp_err;
        inst_pc_q  <= issued_pc_q;
      end
      if (bus.i_redirect) begin
        pending_q <= 1'b1;
      end else if (state_q == FETCH_REDIR) begin
        pending_q <= 1'b0;
      end
      // Kill covers the whole life of a fetch that was redirected mid-flight.
      if (bus.i_redirect && (state_q == FETCH_REQ || state_q == FETCH_WAIT)) begin
        kill_q <= 1'b1;
      end else if (state_q == FETCH_REDIR) begin
        kill_q <= 1'b0;
      end
    end
  end

  assign bus.o_imem_req_valid = req_vld;
  assign bus.o_imem_addr      = req_vld ? bus.i_pc : '0;
  assign bus.o_pc_load        = pc_load;
  assign bus.o_br_sel         = br_sel;
  assign bus.o_br_target      = target_q;
  assign bus.o_inst_valid     = (state_q == FETCH_HOLD);
  assign bus.o_inst           = inst_q;
  assign bus.o_inst_pc        = inst_pc_q;
  // Error flag is only meaningful alongside its own instruction.
  assign bus.o_inst_err       = (state_q == FETCH_HOLD) && inst_err_q;
  assign bus.o_busy           = (state_q != FETCH_IDLE);

endmodule
